// File: rtl/tart_pkg.sv
// Shared constants for the TART receiver front end: register map, CTRL/STATUS
// bit positions and the DATA byte sequencer phases.
package tart_pkg;

   typedef logic [7:0] byte_t;

   localparam logic [6:0] ADDR_CTRL   = 7'h00;
   localparam logic [6:0] ADDR_STATUS = 7'h01;
   localparam logic [6:0] ADDR_COUNT  = 7'h02;
   localparam logic [6:0] ADDR_DATA   = 7'h03;
   localparam logic [6:0] ADDR_ID     = 7'h04;

   localparam int CTRL_CAP_EN = 0;
   localparam int CTRL_FLUSH  = 1;

   localparam int STAT_FULL   = 0;
   localparam int STAT_EMPTY  = 1;
   localparam int STAT_CAP_EN = 2;

   localparam byte_t ID_BYTE_DEFAULT = 8'hA5;
   localparam int    SAMPLE_W        = 24;

   // Which byte of the FIFO head the next DATA load presents.
   typedef enum logic [1:0] {
      PH_HI  = 2'd0,
      PH_MID = 2'd1,
      PH_LO  = 2'd2
   } data_phase_e;

   function automatic data_phase_e next_phase(input data_phase_e p);
      case (p)
         PH_HI:   return PH_MID;
         PH_MID:  return PH_LO;
         default: return PH_HI;
      endcase
   endfunction

endpackage

// File: rtl/tart_spi_slave.sv
// Oversampled SPI mode-0 slave with active-high select: synchronisers, edge
// detection, receive/transmit byte shifters and transaction framing strobes.
module tart_spi_slave
   import tart_pkg::*;
(
   input  logic  rx_clk_16,
   input  logic  reset,
   input  logic  spi_sck,
   input  logic  spi_ssel,
   input  logic  spi_mosi,
   output logic  spi_miso,
   output byte_t rx_byte,
   output logic  rx_valid,
   output logic  cmd_valid,
   output logic  byte_done,
   input  logic  tx_load,
   input  byte_t tx_byte,
   output logic  sel_rise,
   output logic  sel_fall
);

   logic [1:0] sck_sync, ssel_sync, mosi_sync;
   logic       sck_prev, ssel_prev;
   logic [2:0] bit_cnt;
   logic [6:0] rx_shift;
   byte_t      tx_shift;
   logic       first_byte;
   logic       active, sck_rise, sck_fall;

   assign active   = ssel_sync[1];
   assign sck_rise = sck_sync[1] & ~sck_prev;
   assign sck_fall = ~sck_sync[1] & sck_prev;
   assign sel_rise = ssel_sync[1] & ~ssel_prev;
   assign sel_fall = ~ssel_sync[1] & ssel_prev;
   assign spi_miso = tx_shift[7];

   always_ff @(posedge rx_clk_16) begin
      if (reset) begin
         sck_sync   <= '0;
         ssel_sync  <= '0;
         mosi_sync  <= '0;
         sck_prev   <= 1'b0;
         ssel_prev  <= 1'b0;
         bit_cnt    <= '0;
         rx_shift   <= '0;
         tx_shift   <= '0;
         rx_byte    <= '0;
         first_byte <= 1'b0;
         rx_valid   <= 1'b0;
         cmd_valid  <= 1'b0;
         byte_done  <= 1'b0;
      end else begin
         // NOTE: every register here uses <= so all flops sample pre-edge values.
         sck_sync  <= {sck_sync[0], spi_sck};
         ssel_sync <= {ssel_sync[0], spi_ssel};
         mosi_sync <= {mosi_sync[0], spi_mosi};
         sck_prev  <= sck_sync[1];
         ssel_prev <= ssel_sync[1];
         rx_valid  <= 1'b0;
         cmd_valid <= 1'b0;
         byte_done <= 1'b0;

         if (sel_rise) begin
            bit_cnt    <= '0;
            first_byte <= 1'b1;
         end else if (active && sck_rise) begin
            rx_shift <= {rx_shift[5:0], mosi_sync[1]};
            bit_cnt  <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
               rx_byte    <= {rx_shift, mosi_sync[1]};
               byte_done  <= 1'b1;
               cmd_valid  <= first_byte;
               rx_valid   <= ~first_byte;
               first_byte <= 1'b0;
            end
         end

         // The fall that closes a byte must not shift out the freshly loaded MSB.
         if (tx_load)
            tx_shift <= tx_byte;
         else if (active && sck_fall && bit_cnt != 3'd0)
            tx_shift <= {tx_shift[6:0], 1'b0};
      end
   end

endmodule

// File: rtl/tart_core.sv
// TART receiver front end: antenna capture FIFO, SPI-visible register file,
// DATA byte streaming sequencer and FIFO-full LED.
module tart_core
   import tart_pkg::*;
#(
   parameter int    DEPTH   = 16,
   parameter byte_t ID_BYTE = ID_BYTE_DEFAULT
) (
   input  logic                rx_clk_16,
   input  logic                reset,
   input  logic                SPI_SCK,
   input  logic                SPI_SSEL,
   input  logic                SPI_MOSI,
   output logic                SPI_MISO,
   input  logic [SAMPLE_W-1:0] antenna,
   output logic                led
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   byte_t rx_byte, tx_byte;
   logic  rx_valid, cmd_valid, byte_done, tx_load, sel_rise, sel_fall;

   tart_spi_slave u_spi (
      .rx_clk_16 (rx_clk_16),
      .reset     (reset),
      .spi_sck   (SPI_SCK),
      .spi_ssel  (SPI_SSEL),
      .spi_mosi  (SPI_MOSI),
      .spi_miso  (SPI_MISO),
      .rx_byte   (rx_byte),
      .rx_valid  (rx_valid),
      .cmd_valid (cmd_valid),
      .byte_done (byte_done),
      .tx_load   (tx_load),
      .tx_byte   (tx_byte),
      .sel_rise  (sel_rise),
      .sel_fall  (sel_fall)
   );

   logic [SAMPLE_W-1:0] mem [DEPTH];
   logic [SAMPLE_W-1:0] ant_q, head;
   logic [PTR_W-1:0]    wr_ptr, rd_ptr;
   logic [CNT_W-1:0]    count;
   logic                full, empty, push, pop, flush, wr_ctrl, data_rd;
   logic                cap_en, cmd_write, cur_write;
   logic [6:0]          cmd_addr, cur_addr;
   data_phase_e         phase;
   byte_t               status_byte, ctrl_byte, data_byte;

   assign full  = (count == CNT_W'(DEPTH));
   assign empty = (count == '0);
   assign head  = mem[rd_ptr];

   // The command byte's own strobe cycle already needs its address for the first reload.
   assign cur_addr  = cmd_valid ? rx_byte[6:0] : cmd_addr;
   assign cur_write = cmd_valid ? rx_byte[7]   : cmd_write;

   assign wr_ctrl = rx_valid && cmd_write && (cmd_addr == ADDR_CTRL);
   assign flush   = wr_ctrl && rx_byte[CTRL_FLUSH];
   assign push    = cap_en && !full;
   assign data_rd = byte_done && !sel_rise && (cur_addr == ADDR_DATA) && !cur_write && !empty;
   assign pop     = data_rd && (phase == PH_LO);

   always_comb begin
      // NOTE: every always_comb output gets a default first so no latch is inferred.
      status_byte              = '0;
      status_byte[STAT_FULL]   = full;
      status_byte[STAT_EMPTY]  = empty;
      status_byte[STAT_CAP_EN] = cap_en;
      ctrl_byte                = '0;
      ctrl_byte[CTRL_CAP_EN]   = cap_en;
      case (phase)
         PH_HI:   data_byte = head[23:16];
         PH_MID:  data_byte = head[15:8];
         default: data_byte = head[7:0];
      endcase
   end

   always_comb begin
      tx_load = sel_rise | byte_done;
      tx_byte = '0;
      if (sel_rise) begin
         tx_byte = status_byte;
      end else if (byte_done) begin
         case (cur_addr)
            ADDR_CTRL:   tx_byte = ctrl_byte;
            ADDR_STATUS: tx_byte = status_byte;
            ADDR_COUNT:  tx_byte = byte_t'(count);
            ADDR_DATA:   tx_byte = data_rd ? data_byte : 8'h00;
            ADDR_ID:     tx_byte = ID_BYTE;
            default:     tx_byte = 8'h00;
         endcase
      end
   end

   // NOTE: sample storage has no reset; occupancy and pointers alone define validity.
   always_ff @(posedge rx_clk_16) begin
      if (push)
         mem[wr_ptr] <= ant_q;
   end

   always_ff @(posedge rx_clk_16) begin
      if (reset) begin
         ant_q     <= '0;
         cap_en    <= 1'b0;
         cmd_write <= 1'b0;
         cmd_addr  <= '0;
         phase     <= PH_HI;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         led       <= 1'b0;
      end else begin
         ant_q <= antenna;
         led   <= full;

         if (cmd_valid) begin
            cmd_write <= rx_byte[7];
            cmd_addr  <= rx_byte[6:0];
         end
         if (wr_ctrl)
            cap_en <= rx_byte[CTRL_CAP_EN];

         // A partially streamed sample is replayed from its top byte next time.
         if (sel_rise || sel_fall || flush)
            phase <= PH_HI;
         else if (data_rd)
            phase <= next_phase(phase);

         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
         end else begin
            if (push)
               wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
               rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
               2'b10:   count <= count + CNT_W'(1);
               2'b01:   count <= count - CNT_W'(1);
               default: count <= count;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_tart_core.sv
// Self-checking bench for tart_core: SPI register accesses and DATA streaming
// checked against a sample-queue model of the capture FIFO.
module tb_tart_core;

   localparam int HALF  = 8;
   localparam int DEPTH = 16;

   logic        rx_clk_16 = 1'b0;
   logic        reset, SPI_SCK, SPI_SSEL, SPI_MOSI, SPI_MISO, led;
   logic [23:0] antenna;

   logic [7:0]  tx_buf [64];
   logic [7:0]  rx_buf [64];
   logic [23:0] model_q [$];
   int          n_tests = 0;
   int          n_fail  = 0;

   tart_core #(.DEPTH(DEPTH), .ID_BYTE(8'hA5)) dut (
      .rx_clk_16 (rx_clk_16),
      .reset     (reset),
      .SPI_SCK   (SPI_SCK),
      .SPI_SSEL  (SPI_SSEL),
      .SPI_MOSI  (SPI_MOSI),
      .SPI_MISO  (SPI_MISO),
      .antenna   (antenna),
      .led       (led)
   );

   always #5 rx_clk_16 = ~rx_clk_16;

   task automatic tick(input int n);
      repeat (n) @(negedge rx_clk_16);
   endtask

   // Full bytes from tx_buf, optionally followed by a partial byte, then deselect.
   task automatic spi_xfer(input int nbytes, input int extra_bits);
      SPI_SSEL = 1'b1;
      tick(6);
      for (int b = 0; b < nbytes; b++) begin
         for (int i = 7; i >= 0; i--) begin
            SPI_MOSI = tx_buf[b][i];
            tick(HALF);
            rx_buf[b][i] = SPI_MISO;
            SPI_SCK = 1'b1;
            tick(HALF);
            SPI_SCK = 1'b0;
         end
      end
      for (int i = 0; i < extra_bits; i++) begin
         SPI_MOSI = 1'b1;
         tick(HALF);
         SPI_SCK = 1'b1;
         tick(HALF);
         SPI_SCK = 1'b0;
      end
      tick(HALF);
      SPI_SSEL = 1'b0;
      SPI_MOSI = 1'b0;
      tick(6);
   endtask

   task automatic read_reg(input logic [6:0] addr, output logic [7:0] st, output logic [7:0] val);
      tx_buf[0] = {1'b0, addr};
      tx_buf[1] = 8'h00;
      spi_xfer(2, 0);
      st  = rx_buf[0];
      val = rx_buf[1];
   endtask

   task automatic write_reg(input logic [6:0] addr, input logic [7:0] data);
      tx_buf[0] = {1'b1, addr};
      tx_buf[1] = data;
      spi_xfer(2, 0);
   endtask

   task automatic test_reset;
      n_tests++;
      if (SPI_MISO !== 1'b0) begin n_fail++; $display("FAIL reset_miso: got %b want 0", SPI_MISO); end
      n_tests++;
      if (led !== 1'b0) begin n_fail++; $display("FAIL reset_led: got %b want 0", led); end
   endtask

   task automatic test_read_id;
      logic [7:0] st, v;
      read_reg(7'h04, st, v);
      n_tests++;
      if (st !== 8'h02) begin n_fail++; $display("FAIL id_status: got %02h want 02", st); end
      n_tests++;
      if (v !== 8'hA5) begin n_fail++; $display("FAIL id_value: got %02h want a5", v); end
      read_reg(7'h00, st, v);
      n_tests++;
      if (v !== 8'h00) begin n_fail++; $display("FAIL ctrl_reset: got %02h want 00", v); end
      read_reg(7'h02, st, v);
      n_tests++;
      if (v !== 8'h00) begin n_fail++; $display("FAIL count_reset: got %02h want 00", v); end
      read_reg(7'h05 + 7'($urandom_range(0, 120)), st, v);
      n_tests++;
      if (v !== 8'h00) begin n_fail++; $display("FAIL unknown_addr: got %02h want 00", v); end
   endtask

   task automatic test_fill;
      logic [7:0]  st, v;
      logic [23:0] x;
      x = 24'($urandom());
      antenna = x;
      write_reg(7'h00, 8'h01);
      tick(40);
      n_tests++;
      if (led !== 1'b1) begin n_fail++; $display("FAIL fill_led: got %b want 1", led); end
      read_reg(7'h01, st, v);
      n_tests++;
      if (st !== 8'h05 || v !== 8'h05) begin n_fail++; $display("FAIL fill_status: got %02h/%02h want 05/05", st, v); end
      read_reg(7'h02, st, v);
      n_tests++;
      if (v !== 8'(DEPTH)) begin n_fail++; $display("FAIL fill_count: got %0d want %0d", v, DEPTH); end
      model_q.delete();
      for (int i = 0; i < DEPTH; i++) model_q.push_back(x);
   endtask

   // FIFO is full with capture on: every popped sample is refilled with the held antenna value.
   task automatic test_stream;
      logic [7:0]  st, v;
      logic [23:0] val, exp;
      for (int r = 0; r < 6; r++) begin
         val = (r == 0) ? 24'h123456 : (r == 1) ? 24'hABCDEF : 24'($urandom());
         antenna = val;
         tx_buf[0] = 8'h03;
         for (int k = 1; k < 4; k++) tx_buf[k] = 8'($urandom());
         spi_xfer(4, 0);
         exp = model_q.pop_front();
         model_q.push_back(val);
         n_tests++;
         if ({rx_buf[1], rx_buf[2], rx_buf[3]} !== exp) begin
            n_fail++; $display("FAIL stream_%0d: got %02h%02h%02h want %06h", r, rx_buf[1], rx_buf[2], rx_buf[3], exp);
         end
      end
      val = 24'($urandom());
      antenna = val;
      tx_buf[0] = 8'h03;
      for (int k = 1; k < 7; k++) tx_buf[k] = 8'h00;
      spi_xfer(7, 0);
      for (int s = 0; s < 2; s++) begin
         exp = model_q.pop_front();
         model_q.push_back(val);
         n_tests++;
         if ({rx_buf[1+3*s], rx_buf[2+3*s], rx_buf[3+3*s]} !== exp) begin
            n_fail++; $display("FAIL stream6_%0d: got %02h%02h%02h want %06h", s, rx_buf[1+3*s], rx_buf[2+3*s], rx_buf[3+3*s], exp);
         end
      end
      write_reg(7'h00, 8'h00);
      read_reg(7'h01, st, v);
      n_tests++;
      if (v !== 8'h01) begin n_fail++; $display("FAIL stream_status: got %02h want 01", v); end
      read_reg(7'h02, st, v);
      n_tests++;
      if (v !== 8'(DEPTH)) begin n_fail++; $display("FAIL stream_count: got %0d want %0d", v, DEPTH); end
   endtask

   task automatic test_abort;
      logic [7:0] st, v;
      tx_buf[0] = 8'h03;
      tx_buf[1] = 8'h00;
      spi_xfer(2, 5);
      n_tests++;
      if (rx_buf[1] !== model_q[0][23:16]) begin n_fail++; $display("FAIL abort_byte: got %02h want %02h", rx_buf[1], model_q[0][23:16]); end
      read_reg(7'h02, st, v);
      n_tests++;
      if (v !== 8'(model_q.size())) begin n_fail++; $display("FAIL abort_count: got %0d want %0d", v, model_q.size()); end
      tx_buf[0] = 8'h03;
      for (int k = 1; k < 4; k++) tx_buf[k] = 8'h00;
      spi_xfer(4, 0);
      n_tests++;
      if ({rx_buf[1], rx_buf[2], rx_buf[3]} !== model_q[0]) begin
         n_fail++; $display("FAIL abort_reread: got %02h%02h%02h want %06h", rx_buf[1], rx_buf[2], rx_buf[3], model_q[0]);
      end
      void'(model_q.pop_front());
      read_reg(7'h02, st, v);
      n_tests++;
      if (v !== 8'(model_q.size())) begin n_fail++; $display("FAIL pop_count: got %0d want %0d", v, model_q.size()); end
      n_tests++;
      if (led !== 1'b0) begin n_fail++; $display("FAIL pop_led: got %b want 0", led); end
   endtask

   task automatic test_drain;
      logic [7:0]  st, v;
      logic [23:0] exp;
      int          n;
      n = model_q.size();
      tx_buf[0] = 8'h03;
      for (int k = 1; k < 3*n + 2; k++) tx_buf[k] = 8'h00;
      spi_xfer(3*n + 2, 0);
      for (int s = 0; s < n; s++) begin
         exp = model_q.pop_front();
         n_tests++;
         if ({rx_buf[1+3*s], rx_buf[2+3*s], rx_buf[3+3*s]} !== exp) begin
            n_fail++; $display("FAIL drain_%0d: got %02h%02h%02h want %06h", s, rx_buf[1+3*s], rx_buf[2+3*s], rx_buf[3+3*s], exp);
         end
      end
      n_tests++;
      if (rx_buf[3*n+1] !== 8'h00) begin n_fail++; $display("FAIL drain_empty_byte: got %02h want 00", rx_buf[3*n+1]); end
      read_reg(7'h01, st, v);
      n_tests++;
      if (v !== 8'h02) begin n_fail++; $display("FAIL drain_status: got %02h want 02", v); end
   endtask

   task automatic test_flush;
      logic [7:0] st, v;
      antenna = 24'($urandom());
      write_reg(7'h00, 8'h01);
      tick(40);
      n_tests++;
      if (led !== 1'b1) begin n_fail++; $display("FAIL flush_pre_led: got %b want 1", led); end
      tx_buf[0] = 8'h80;
      tx_buf[1] = 8'h03;
      tx_buf[2] = 8'h02;
      spi_xfer(3, 0);
      n_tests++;
      if (led !== 1'b0) begin n_fail++; $display("FAIL flush_led: got %b want 0", led); end
      read_reg(7'h02, st, v);
      n_tests++;
      if (v !== 8'h00 || st !== 8'h02) begin n_fail++; $display("FAIL flush_count: got %0d/%02h want 0/02", v, st); end
      read_reg(7'h00, st, v);
      n_tests++;
      if (v !== 8'h00) begin n_fail++; $display("FAIL flush_ctrl: got %02h want 00", v); end
      tx_buf[0] = 8'h03;
      tx_buf[1] = 8'h00;
      tx_buf[2] = 8'h00;
      spi_xfer(3, 0);
      n_tests++;
      if (rx_buf[1] !== 8'h00 || rx_buf[2] !== 8'h00) begin n_fail++; $display("FAIL flush_data: got %02h %02h want 00 00", rx_buf[1], rx_buf[2]); end
      write_reg(7'h01, 8'hFF);
      read_reg(7'h01, st, v);
      n_tests++;
      if (v !== 8'h02) begin n_fail++; $display("FAIL ro_status: got %02h want 02", v); end
      write_reg(7'h04, 8'h00);
      read_reg(7'h04, st, v);
      n_tests++;
      if (v !== 8'hA5) begin n_fail++; $display("FAIL ro_id: got %02h want a5", v); end
   endtask

   task automatic test_reset_mid;
      logic [7:0] st, v;
      antenna = 24'($urandom());
      write_reg(7'h00, 8'h01);
      tick(40);
      SPI_SSEL = 1'b1;
      tick(6);
      for (int i = 0; i < 3; i++) begin
         SPI_MOSI = 1'b1;
         tick(HALF);
         SPI_SCK = 1'b1;
         tick(HALF);
         SPI_SCK = 1'b0;
      end
      reset = 1'b1;
      tick(2);
      n_tests++;
      if (SPI_MISO !== 1'b0 || led !== 1'b0) begin n_fail++; $display("FAIL midreset_out: got miso=%b led=%b want 0 0", SPI_MISO, led); end
      reset = 1'b0;
      SPI_SSEL = 1'b0;
      SPI_MOSI = 1'b0;
      tick(6);
      read_reg(7'h00, st, v);
      n_tests++;
      if (v !== 8'h00 || st !== 8'h02) begin n_fail++; $display("FAIL midreset_ctrl: got %02h/%02h want 00/02", v, st); end
      read_reg(7'h02, st, v);
      n_tests++;
      if (v !== 8'h00) begin n_fail++; $display("FAIL midreset_count: got %0d want 0", v); end
      read_reg(7'h04, st, v);
      n_tests++;
      if (v !== 8'hA5) begin n_fail++; $display("FAIL midreset_id: got %02h want a5", v); end
   endtask

   initial begin
      reset    = 1'b1;
      SPI_SCK  = 1'b0;
      SPI_SSEL = 1'b0;
      SPI_MOSI = 1'b0;
      antenna  = '0;
      tick(4);
      test_reset;
      reset = 1'b0;
      tick(4);
      test_read_id;
      test_fill;
      test_stream;
      test_abort;
      test_drain;
      test_flush;
      test_reset_mid;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
